// File: rtl/dlfloat_pkg.sv
// rtl/dlfloat_pkg.sv - shared DLFloat16 constants and MAC scheduler state type
package dlfloat_pkg;

    localparam int DLF_W = 16;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/dlfloat_rr_arb.sv
// rtl/dlfloat_rr_arb.sv - combinational round-robin pick of the next requester after last
module dlfloat_rr_arb
    import dlfloat_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest hit after last wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IW'((int'(last) + off) % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dlfloat_mac_sched.sv
// rtl/dlfloat_mac_sched.sv - round-robin dot-product job scheduler for a shared DLFloat16 MAC (watchdog: DLMAC_SCHED_TIMEOUT_EN)
module dlfloat_mac_sched
    import dlfloat_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2,
    parameter int TO_W    = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          job_req,
    input  logic [NREQ*LEN_W-1:0]    job_len,
    output logic [NREQ-1:0]          grant,
    input  logic [NREQ-1:0]          op_valid,
    input  logic [NREQ*DLF_W-1:0]    op_a,
    input  logic [NREQ*DLF_W-1:0]    op_b,
    output logic [NREQ-1:0]          op_ready,
    output logic [DLF_W-1:0]         mac_a,
    output logic [DLF_W-1:0]         mac_b,
    output logic                     mac_clr,
    input  logic [DLF_W-1:0]         mac_acc,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DLF_W-1:0]         res_data,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     res_err
);

    localparam int IW    = $clog2(NREQ);
    localparam int LAT_W = $clog2(MAC_LAT + 1);

    sched_state_t     state;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    win;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [LAT_W-1:0] lat_cnt;

    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    logic [LEN_W-1:0] len_lane [NREQ];
    logic [DLF_W-1:0] a_lane   [NREQ];
    logic [DLF_W-1:0] b_lane   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign len_lane[i] = job_len[i*LEN_W +: LEN_W];
        assign a_lane[i]   = op_a[i*DLF_W +: DLF_W];
        assign b_lane[i]   = op_b[i*DLF_W +: DLF_W];
    end

    dlfloat_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req  (job_req),
        .last (last_idx),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

`ifdef DLMAC_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_to_w;
    assign unused_to_w = (TO_W > 0);
`endif

    // Job sequencing: grant, clear, stream pairs, drain the MAC pipeline, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_idx  <= IW'(NREQ - 1);
            win       <= '0;
            len       <= '0;
            cnt       <= '0;
            lat_cnt   <= '0;
            grant     <= '0;
            op_ready  <= '0;
            mac_a     <= DLF_ZERO;
            mac_b     <= DLF_ZERO;
            mac_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= DLF_ZERO;
            res_id    <= '0;
            res_err   <= 1'b0;
`ifdef DLMAC_SCHED_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            // Idle operand slots feed zeros so the accumulator is left untouched.
            mac_clr <= 1'b0;
            mac_a   <= DLF_ZERO;
            mac_b   <= DLF_ZERO;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant   <= arb_gnt;
                        win     <= arb_idx;
                        len     <= len_lane[arb_idx];
                        mac_clr <= 1'b1;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    cnt     <= '0;
                    lat_cnt <= '0;
`ifdef DLMAC_SCHED_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    if (len == '0) begin
                        state <= DRAIN;
                    end else begin
                        op_ready <= grant;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (op_valid[win] && op_ready[win]) begin
                        mac_a <= a_lane[win];
                        mac_b <= b_lane[win];
                        cnt   <= cnt + LEN_W'(1);
`ifdef DLMAC_SCHED_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (cnt + LEN_W'(1) == len) begin
                            op_ready <= '0;
                            state    <= DRAIN;
                        end
                    end
`ifdef DLMAC_SCHED_TIMEOUT_EN
                    else if (to_cnt == {TO_W{1'b1}}) begin
                        op_ready  <= '0;
                        res_valid <= 1'b1;
                        res_data  <= DLF_NAN;
                        res_id    <= win;
                        res_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                DRAIN: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (lat_cnt == LAT_W'(MAC_LAT - 1)) begin
                        res_valid <= 1'b1;
                        res_data  <= mac_acc;
                        res_id    <= win;
                        res_err   <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        grant     <= '0;
                        last_idx  <= win;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_sched.sv
// tb/tb_dlfloat_mac_sched.sv - randomized self-checking bench for dlfloat_mac_sched
module tb_dlfloat_mac_sched;

    localparam int NREQ    = 2;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;
`ifdef DLMAC_SCHED_TIMEOUT_EN
    localparam int TO_W    = 4;
`else
    localparam int TO_W    = 6;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         job_req = '0;
    logic [NREQ*LEN_W-1:0]   job_len = '0;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         op_valid = '0;
    logic [NREQ*16-1:0]      op_a = '0;
    logic [NREQ*16-1:0]      op_b = '0;
    logic [NREQ-1:0]         op_ready;
    logic [15:0]             mac_a, mac_b;
    logic                    mac_clr;
    logic [15:0]             mac_acc;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic [15:0]             res_data;
    logic [$clog2(NREQ)-1:0] res_id;
    logic                    res_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          grant_wait;
    int          rr_last;
    int          lane_len [NREQ];
    logic [15:0] ja [NREQ][16];
    logic [15:0] jb [NREQ][16];
    logic [15:0] last_res;
    logic [15:0] op_tab [6] = '{16'h3E00, 16'h4000, 16'h3C00, 16'h3F00, 16'hBE00, 16'h0000};

    dlfloat_mac_sched #(
        .NREQ(NREQ), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .job_req(job_req), .job_len(job_len), .grant(grant),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_err(res_err)
    );

    always #5 clk = ~clk;

    function automatic real dlf2real(input logic [15:0] x);
        real v;
        int  e;
        if (x[14:0] == 15'd0) return 0.0;
        v = 1.0 + real'(int'(x[8:0])) / 512.0;
        e = int'(x[14:9]) - 31;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real2dlf(input real r);
        real  v;
        int   e, m;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        v = s ? -r : r;
        e = 31;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        m = $rtoi((v - 1.0) * 512.0);
        return {s, 6'(e), 9'(m)};
    endfunction

    // Accumulator model: one pair per cycle, product lands on mac_acc in the following cycle.
    real acc_r = 0.0;
    always @(posedge clk) begin
        if (mac_clr) acc_r <= 0.0;
        else         acc_r <= acc_r + dlf2real(mac_a) * dlf2real(mac_b);
    end
    assign mac_acc = real2dlf(acc_r);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] p, input int lst);
        for (int off = 1; off <= NREQ; off++)
            if (p[(lst + off) % NREQ]) return (lst + off) % NREQ;
        return 0;
    endfunction

    task automatic raise(input int w, input int len);
        lane_len[w] = len;
        job_len[w*LEN_W +: LEN_W] = LEN_W'(len);
        job_req[w] = 1'b1;
    endtask

    task automatic fill_random(input int w);
        for (int i = 0; i < 16; i++) begin
            ja[w][i] = op_tab[$urandom_range(0, 5)];
            jb[w][i] = op_tab[$urandom_range(0, 5)];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; job_req = '0; op_valid = '0; res_ready = 1'b0;
        #1;
        check("reset_outs", {grant, op_ready, mac_clr, res_valid, res_err, res_id,
                             mac_a, mac_b, res_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rr_last = NREQ - 1;
    endtask

    // Serve one job on lane w: vmode 0 = always valid, 1 = toggling, 2 = random.
    task automatic do_job(input int w, input int vmode, input int stall);
        int          cyc, n, last_acc, len;
        bit          seen, done, v, acc_prev;
        logic [15:0] pa, pb, exp_res;
        real         sum;
        len = lane_len[w];
        seen = 0;
        grant_wait = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) begin seen = 1; grant_wait = i; end
        end
        check("grant_seen", seen, 1);
        check("grant", grant, 64'd1 << w);
        check("mac_clr", mac_clr, 1);
        check("ready_in_clr", op_ready, 0);
        job_req[w] = 1'b0;
        cyc = 0; n = 0; last_acc = 0; acc_prev = 0; sum = 0.0; done = 0; pa = '0; pb = '0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            check("mac_a", mac_a, acc_prev ? pa : 16'h0);
            check("mac_b", mac_b, acc_prev ? pb : 16'h0);
            acc_prev = 0;
            if (res_valid) begin
                done = 1;
            end else begin
                check("op_ready", op_ready, (n < len) ? (64'd1 << w) : 64'd0);
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = cyc[0];
                    default: v = 1'($urandom_range(0, 1));
                endcase
                op_valid = NREQ'($urandom);
                op_valid[w] = v;
                op_a = {$urandom, $urandom};
                op_b = {$urandom, $urandom};
                op_a[w*16 +: 16] = ja[w][n];
                op_b[w*16 +: 16] = jb[w][n];
                if (op_ready[w] && v) begin
                    pa = ja[w][n];
                    pb = jb[w][n];
                    sum += dlf2real(pa) * dlf2real(pb);
                    n++;
                    last_acc = cyc;
                    acc_prev = 1;
                end
            end
        end
        op_valid = '0;
        exp_res = real2dlf(sum);
        check("res_seen", done, 1);
        check("latency", cyc - last_acc, MAC_LAT + 1);
        check("accepts", n, len);
        check("res_data", res_data, exp_res);
        check("res_id", res_id, w);
        check("res_err", res_err, 0);
        last_res = res_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", res_valid, 1);
            check("stall_data", res_data, exp_res);
            check("stall_grant", grant, 64'd1 << w);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("hs_valid", res_valid, 0);
        check("hs_grant", grant, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] pend;
        int              w;
        bit              seen;

        @(negedge clk);
        do_reset();

        // Single job 1*2 + 1*1 = 3.0
        ja[0][0] = 16'h3E00; jb[0][0] = 16'h4000;
        ja[0][1] = 16'h3E00; jb[0][1] = 16'h3E00;
        raise(0, 2);
        do_job(0, 0, 0);
        check("t1_grant_lat", grant_wait, 1);
        check("t1_sum", last_res, 16'h4100);

        // Simultaneous requests after reset: 0, 1, then 0 again
        do_reset();
        fill_random(0); fill_random(1);
        raise(0, 1); raise(1, 1);
        do_job(0, 2, 0);
        do_job(1, 2, 1);
        raise(0, 1); raise(1, 1);
        do_job(0, 2, 0);
        do_job(1, 2, 0);

        // Zero-length job on lane 1
        raise(1, 0);
        do_job(1, 2, 1);
        check("len0_res", last_res, 16'h0000);

        // Toggling valid with a long result stall
        fill_random(0);
        raise(0, 3);
        do_job(0, 1, 5);

        // Reset in the middle of RUN, then resubmit
        raise(0, 4);
        op_valid = '0;
        op_a[15:0] = 16'h4000; op_b[15:0] = 16'h4000;
        @(negedge clk);
        check("rm_grant", grant, 1);
        op_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("rm_ready", op_ready, 1);
        rst_n = 1'b0; job_req = '0; op_valid = '0;
        #1;
        check("rst_mid_outs", {grant, op_ready, mac_clr, res_valid, res_err, res_id,
                               mac_a, mac_b, res_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ja[0][0] = 16'h3F00; jb[0][0] = 16'h4000;
        ja[0][1] = 16'h3C00; jb[0][1] = 16'h3E00;
        ja[0][2] = 16'hBE00; jb[0][2] = 16'h3C00;
        raise(0, 3);
        do_job(0, 0, 0);
        check("rm_resubmit", last_res, 16'h4100);

        // Randomized request mixes against the round-robin model
        do_reset();
        for (int r = 0; r < 12; r++) begin
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int l = 0; l < NREQ; l++)
                if (pend[l]) begin
                    fill_random(l);
                    raise(l, $urandom_range(0, 6));
                end
            while (pend != '0) begin
                w = rr_pick(pend, rr_last);
                do_job(w, 2, $urandom_range(0, 3));
                pend[w] = 1'b0;
                rr_last = w;
            end
        end

`ifdef DLMAC_SCHED_TIMEOUT_EN
        // Watchdog abort with no operands offered
        raise(0, 3);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (grant != '0) seen = 1;
        end
        check("to_grant", grant, 1);
        job_req = '0;
        op_valid = '0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        check("to_seen", seen, 1);
        check("to_data", res_data, 16'hFFFF);
        check("to_err", res_err, 1);
        check("to_id", res_id, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("to_hs", {res_valid, res_err, grant}, 0);
`else
        seen = 0;
        check("no_to_seen", seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
